// File: rtl/new_means_sequencer.sv
// Walks centroids 0..7, divides each coordinate sum by its point count and presents the mean.
// Optional build macro NEW_MEANS_ROUND_EN selects round-half-away-from-zero instead of truncation.
module new_means_sequencer #(
  parameter int accum_cord_width = 22,
  parameter int cordinate_width  = 13,
  parameter int count_width      = 10,
  parameter int centroid_num     = 8,
  parameter int accum_width      = 7 * accum_cord_width,
  parameter int dataWidth        = 7 * cordinate_width
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(centroid_num)-1:0] acc_rd_addr,
  input  logic [accum_width-1:0]          accum_in,
  input  logic [count_width-1:0]          count_in,
  output logic [dataWidth-1:0]            new_centroid,
  output logic [$clog2(centroid_num)-1:0] cent_num,
  output logic                            divide_by_0,
  output logic                            convergence_reg_en,
  output logic                            convergence_regs_reset_n
);

  localparam int num_cords  = 7;
  localparam int idx_width  = $clog2(centroid_num);
  localparam int div_width  = accum_cord_width + 1;
  localparam int iter_width = $clog2(div_width);
  localparam logic [iter_width-1:0] last_iter = iter_width'(div_width - 1);
  localparam logic [idx_width-1:0]  last_idx  = idx_width'(centroid_num - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DIV, PRESENT, DONE} state_t;

  state_t state, state_next;

  logic [idx_width-1:0]                    idx;
  logic [iter_width-1:0]                   iter;
  logic [count_width-1:0]                  divisor;
  logic [num_cords-1:0]                    neg;
  logic [num_cords-1:0][div_width-1:0]     sum_ext;
  logic [num_cords-1:0][div_width-1:0]     dividend;
  logic [num_cords-1:0][div_width-1:0]     quo;
  logic [num_cords-1:0][div_width-1:0]     quo_step;
  logic [num_cords-1:0][count_width-1:0]   rem;
  logic [num_cords-1:0][count_width-1:0]   rem_step;
  logic [num_cords-1:0][count_width:0]     rem_shift;
  logic [dataWidth-1:0]                    mean;
  logic                                    count_zero;

  assign count_zero = (count_in == '0);

  // The extra dividend bit holds the magnitude of the most negative sum and any rounding carry
  always_comb begin
    sum_ext  = '0;
    dividend = '0;
    for (int c = 0; c < num_cords; c++) begin
      sum_ext[c] = {accum_in[(c+1)*accum_cord_width-1], accum_in[c*accum_cord_width +: accum_cord_width]};
`ifdef NEW_MEANS_ROUND_EN
      dividend[c] = (sum_ext[c][div_width-1] ? -sum_ext[c] : sum_ext[c]) + div_width'(count_in >> 1);
`else
      dividend[c] = sum_ext[c][div_width-1] ? -sum_ext[c] : sum_ext[c];
`endif
    end
  end

  // One restoring step for all seven dividers; the remainder always stays below the divisor
  always_comb begin
    rem_shift = '0;
    rem_step  = '0;
    quo_step  = '0;
    mean      = '0;
    for (int c = 0; c < num_cords; c++) begin
      rem_shift[c] = {rem[c], quo[c][div_width-1]};
      if (rem_shift[c] >= {1'b0, divisor}) begin
        rem_step[c] = count_width'(rem_shift[c] - {1'b0, divisor});
        quo_step[c] = {quo[c][div_width-2:0], 1'b1};
      end else begin
        rem_step[c] = rem_shift[c][count_width-1:0];
        quo_step[c] = {quo[c][div_width-2:0], 1'b0};
      end
      mean[c*cordinate_width +: cordinate_width] = neg[c] ? -quo_step[c][cordinate_width-1:0]
                                                          : quo_step[c][cordinate_width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = FETCH;
      FETCH:   state_next = count_zero ? PRESENT : DIV;
      DIV:     if (iter == last_iter) state_next = PRESENT;
      PRESENT: state_next = (idx == last_idx) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg     <= '0;
      iter    <= '0;
    end else if (state == FETCH) begin
      quo     <= dividend;
      rem     <= '0;
      divisor <= count_in;
      iter    <= '0;
      for (int c = 0; c < num_cords; c++) neg[c] <= accum_in[(c+1)*accum_cord_width-1];
    end else if (state == DIV) begin
      quo  <= quo_step;
      rem  <= rem_step;
      iter <= iter + iter_width'(1);
    end
  end

  // Outputs are registered from the next state so all PRESENT-side signals move on one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      busy                     <= 1'b0;
      done                     <= 1'b0;
      acc_rd_addr              <= '0;
      new_centroid             <= '0;
      cent_num                 <= '0;
      divide_by_0              <= 1'b0;
      convergence_reg_en       <= 1'b0;
      convergence_regs_reset_n <= 1'b0;
      idx                      <= '0;
    end else begin
      busy               <= (state_next != IDLE);
      done               <= (state_next == DONE);
      convergence_reg_en <= (state_next == PRESENT);
      case (state_next)
        CLEAR: begin
          convergence_regs_reset_n <= 1'b0;
          acc_rd_addr              <= '0;
          idx                      <= '0;
        end
        FETCH: begin
          convergence_regs_reset_n <= 1'b1;
          if (state == PRESENT) idx <= idx + 1'b1;
        end
        PRESENT: begin
          cent_num     <= idx;
          acc_rd_addr  <= idx + 1'b1;
          new_centroid <= (state == FETCH) ? '0 : mean;
          divide_by_0  <= (state == FETCH);
        end
        DONE:    cent_num <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_new_means_sequencer.sv
// Bench for new_means_sequencer: directed and random passes checked against a schedule/mean model.
// Build with +define+NEW_MEANS_ROUND_EN to check the rounding variant.
`timescale 1ns/1ps
module tb_new_means_sequencer;
  localparam int acw  = 22;
  localparam int cw   = 13;
  localparam int cntw = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [2:0]    accRdAddr;
  logic [153:0]  accumIn;
  logic [9:0]    countIn;
  logic [90:0]   newCentroid;
  logic [2:0]    centNum;
  logic          divideBy0;
  logic          convergenceRegEn;
  logic          convergenceRegsResetN;

  int sums [8][7];
  int counts [8];
  int errors = 0;
  int checks = 0;

  new_means_sequencer dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .busy                     (busy),
    .done                     (done),
    .acc_rd_addr              (accRdAddr),
    .accum_in                 (accumIn),
    .count_in                 (countIn),
    .new_centroid             (newCentroid),
    .cent_num                 (centNum),
    .divide_by_0              (divideBy0),
    .convergence_reg_en       (convergenceRegEn),
    .convergence_regs_reset_n (convergenceRegsResetN)
  );

  always #5 clk = ~clk;

  // Accumulator bank: data returns one cycle after the address
  always @(posedge clk) begin
    for (int c = 0; c < 7; c++) accumIn[c*acw +: acw] <= acw'(sums[accRdAddr][c]);
    countIn <= cntw'(counts[accRdAddr]);
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [90:0] expMean(input int k);
    logic [90:0] word;
    logic [12:0] low;
    longint      mag;
    longint      q;
    word = '0;
    if (counts[k] == 0) return word;
    for (int c = 0; c < 7; c++) begin
      mag = (sums[k][c] < 0) ? -longint'(sums[k][c]) : longint'(sums[k][c]);
`ifdef NEW_MEANS_ROUND_EN
      mag = mag + longint'(counts[k] / 2);
`endif
      q = mag / longint'(counts[k]);
      if (sums[k][c] < 0) q = -q;
      low = q[12:0];
      word[c*cw +: cw] = low;
    end
    return word;
  endfunction

  task automatic fillUniform(input int cnt, input int sum);
    for (int k = 0; k < 8; k++) begin
      counts[k] = cnt;
      for (int c = 0; c < 7; c++) sums[k][c] = sum;
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 8; k++) begin
      counts[k] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1023));
      for (int c = 0; c < 7; c++) sums[k][c] = int'($urandom_range(0, 4000000)) - 2000000;
    end
  endtask

  // One pass from start acceptance; optional stray starts, held start, or a reset at a given cycle
  task automatic applyStimulus(input bit holdStart, input int extraStart1, input int extraStart2, input int resetAt);
    int evCycle [8];
    int expDone;
    int t;
    int cyc;
    int nEv;
    int cent7;
    int strobes;
    int expBeforeRst;
    bit doneSeen;
    t = 2;
    for (int k = 0; k < 8; k++) begin
      evCycle[k] = t + ((counts[k] == 0) ? 1 : 24);
      t = evCycle[k] + 1;
    end
    expDone  = evCycle[7] + 1;
    nEv      = 0;
    cent7    = 0;
    doneSeen = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc   = 1;
    start = holdStart;
    while (!doneSeen && cyc < 400) begin
      if (cyc == 1) begin
        checkOutput("clearResetN", convergenceRegsResetN, 0);
        checkOutput("clearBusy", busy, 1);
        checkOutput("clearAddr", accRdAddr, 0);
      end
      if (cyc == 2) checkOutput("fetchResetN", convergenceRegsResetN, 1);
      if (centNum == 3'd7) cent7++;
      if (convergenceRegEn) begin
        if (nEv < 8) begin
          checkOutput("presentCycle", cyc, evCycle[nEv]);
          checkOutput("centNum", centNum, nEv);
          checkOutput("divBy0", divideBy0, counts[nEv] == 0);
          checkOutput("newCentroid", newCentroid, expMean(nEv));
          checkOutput("presentAddr", accRdAddr, (nEv + 1) % 8);
        end else begin
          checkOutput("extraPresent", nEv, 7);
        end
        nEv++;
      end
      if (done) begin
        checkOutput("doneCycle", cyc, expDone);
        checkOutput("doneCentNum", centNum, 0);
        doneSeen = 1'b1;
      end
      if (cyc == resetAt) begin
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstAddr", accRdAddr, 0);
        checkOutput("rstNewCentroid", newCentroid, 0);
        checkOutput("rstCentNum", centNum, 0);
        checkOutput("rstDivBy0", divideBy0, 0);
        checkOutput("rstRegEn", convergenceRegEn, 0);
        checkOutput("rstResetN", convergenceRegsResetN, 0);
        expBeforeRst = 0;
        for (int k = 0; k < 8; k++) if (evCycle[k] <= resetAt) expBeforeRst++;
        checkOutput("presentsBeforeRst", nEv, expBeforeRst);
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (convergenceRegEn || busy) strobes++;
        end
        checkOutput("postRstActivity", strobes, 0);
        return;
      end
      if (!doneSeen) begin
        start = holdStart || (cyc == extraStart1) || (cyc == extraStart2);
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("doneSeen", doneSeen, 1);
    checkOutput("presentCount", nEv, 8);
    checkOutput("cent7Cycles", cent7, 1);
    @(negedge clk);
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleDone", done, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fillUniform(10, 100);
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetAddr", accRdAddr, 0);
    checkOutput("resetNewCentroid", newCentroid, 0);
    checkOutput("resetCentNum", centNum, 0);
    checkOutput("resetDivBy0", divideBy0, 0);
    checkOutput("resetRegEn", convergenceRegEn, 0);
    checkOutput("resetResetN", convergenceRegsResetN, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, -1, -1, -1);

    fillUniform(4, 40);
    counts[3] = 0;
    applyStimulus(1'b0, -1, -1, -1);

    fillRandom();
    counts[0]  = 10;
    sums[0][0] = -25;
    sums[0][1] = 25;
    counts[1]  = 512;
    sums[1][0] = 2096640;
    sums[1][1] = -2096640;
    applyStimulus(1'b0, -1, -1, -1);

    fillUniform(10, 100);
    applyStimulus(1'b0, 50, 100, -1);
    applyStimulus(1'b0, -1, -1, 110);
    applyStimulus(1'b0, -1, -1, -1);

    fillRandom();
    applyStimulus(1'b1, -1, -1, -1);
    fillRandom();
    applyStimulus(1'b0, -1, -1, -1);

    repeat (4) begin
      fillRandom();
      applyStimulus(1'b0, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
